// File: rtl/rr_mux4_pkg.sv
// Shared constants, grant bundle and round-robin pick helper for rr_mux4.
package rr_mux4_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] grant;
  } pick_t;

  // First full channel scanning from ptr upward, 2-bit wrap.
  function automatic pick_t rr_pick(
    input logic [NCH-1:0]   full,
    input logic [SEL_W-1:0] ptr
  );
    pick_t            p;
    logic [SEL_W-1:0] idx;
    p = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = ptr + SEL_W'(k);
      if (!p.found && full[idx]) begin
        p.found = 1'b1;
        p.grant = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_mux4_if.sv
// Handshake bundle between four producers, rr_mux4 and the downstream sink.
interface rr_mux4_if #(
  parameter int W = 4
);

  localparam int NCH   = rr_mux4_pkg::NCH;
  localparam int SEL_W = rr_mux4_pkg::SEL_W;

  logic [NCH-1:0]   in_valid;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );

endinterface

// File: rtl/rr_mux4_arb4.sv
// Combinational 4-way round-robin picker; the pointer register lives
// in the parent.
module rr_arb4
  import rr_mux4_pkg::*;
(
  input  logic [NCH-1:0]   full,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             found
);

  pick_t pick;

  always_comb begin
    pick  = rr_pick(full, ptr);
    grant = pick.grant;
    found = pick.found;
  end

endmodule

// File: rtl/rr_mux4.sv
// 4:1 round-robin TDM mux with per-channel holding registers and tagged
// output. RR_MUX4_FIXED_PRIO_EN selects fixed priority (ch0 highest).
module rr_mux4
  import rr_mux4_pkg::*;
#(
  parameter int W = 4
) (
  input logic       clk,
  input logic       rst,
  rr_mux4_if.slave  bus
);

  logic [NCH-1:0]   full;
  logic [W-1:0]     hold [NCH];
  logic             ov;
  logic [W-1:0]     od;
  logic [SEL_W-1:0] os;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic             found;
  logic             slot_free;

`ifdef RR_MUX4_FIXED_PRIO_EN
  // Scanning from 0 every time turns the picker into fixed priority.
  assign ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (slot_free && found)
      ptr <= grant + SEL_W'(1);
  end
`endif

  rr_arb4 u_arb (
    .full  (full),
    .ptr   (ptr),
    .grant (grant),
    .found (found)
  );

  assign slot_free = !ov || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      ov   <= 1'b0;
      od   <= '0;
      os   <= '0;
      for (int i = 0; i < NCH; i++)
        hold[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.in_valid[i] && !full[i]) begin
          hold[i] <= bus.in_data[i*W +: W];
          full[i] <= 1'b1;
        end
      end
      // Granted channel is full, so its clear never meets a load.
      if (slot_free) begin
        if (found) begin
          ov          <= 1'b1;
          od          <= hold[grant];
          os          <= grant;
          full[grant] <= 1'b0;
        end else begin
          ov <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.out_sel   = os;

endmodule

// File: tb/tb_rr_mux4.sv
// Directed and random stimulus for rr_mux4 against a behavioural model.
module tb_rr_mux4;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bit   m_full [4];
  int   m_hold [4];
  bit   m_ov;
  int   m_od;
  int   m_os;
  int   m_ptr;

  rr_mux4_if #(.W(W)) bus ();

  rr_mux4 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    bit nf [4];
    int nh [4];
    bit found;
    int g;
    int c;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] = 0;
        m_hold[i] = 0;
      end
      m_ov  = 0;
      m_od  = 0;
      m_os  = 0;
      m_ptr = 0;
      return;
    end
    nf    = m_full;
    nh    = m_hold;
    found = 0;
    g     = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.in_valid[i] && !m_full[i]) begin
        nf[i] = 1;
        nh[i] = int'((bus.in_data >> (i*W)) & ((1 << W) - 1));
      end
    end
    if (!m_ov || bus.out_ready) begin
      for (int k = 0; k < 4; k++) begin
`ifdef RR_MUX4_FIXED_PRIO_EN
        c = k;
`else
        c = (m_ptr + k) % 4;
`endif
        if (!found && m_full[c]) begin
          found = 1;
          g     = c;
        end
      end
      if (found) begin
        m_ov  = 1;
        m_od  = m_hold[g];
        m_os  = g;
        nf[g] = 0;
        m_ptr = (g + 1) % 4;
      end else begin
        m_ov = 0;
      end
    end
    m_full = nf;
    m_hold = nh;
  endfunction

  task automatic compare_model();
    int er;
    er = 0;
    for (int i = 0; i < 4; i++)
      if (!m_full[i]) er |= (1 << i);
    chk("in_ready", 32'(bus.in_ready), er);
    chk("out_valid", 32'(bus.out_valid), m_ov);
    chk("out_data", 32'(bus.out_data), m_od);
    chk("out_sel", 32'(bus.out_sel), m_os);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic expect_out(string tag, int v, int d, int s);
    chk({tag, ".v"}, 32'(bus.out_valid), v);
    if (v != 0) begin
      chk({tag, ".d"}, 32'(bus.out_data), d);
      chk({tag, ".s"}, 32'(bus.out_sel), s);
    end
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;

    // Reset then idle
    tick();
    tick();
    chk("rst.ready", 32'(bus.in_ready), 32'hF);
    expect_out("rst", 0, 0, 0);
    chk("rst.data", 32'(bus.out_data), 0);
    chk("rst.sel", 32'(bus.out_sel), 0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle.ready", 32'(bus.in_ready), 32'hF);

    // Single channel
    bus.in_valid = 4'b0100;
    bus.in_data  = 16'h0A00;
    tick();
    chk("single.acc", 32'(bus.in_ready), 32'hB);
    bus.in_valid = '0;
    tick();
    expect_out("single", 1, 4'hA, 2);
    tick();
    expect_out("single.end", 0, 0, 0);

    // All four full, from ptr = 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 4'b1111;
    bus.in_data  = 16'h4321;
    tick();
    bus.in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_out("all4", 1, k + 1, k);
    end
    tick();

    // Backpressure
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1010;
    bus.in_data   = 16'h7050;
    tick();
    bus.in_valid = '0;
    tick();
    expect_out("bp.first", 1, 5, 1);
    repeat (3) begin
      tick();
      expect_out("bp.hold", 1, 5, 1);
      chk("bp.ready3", 32'(bus.in_ready[3]), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    expect_out("bp.next", 1, 7, 3);
    tick();

    // Fairness wrap: ptr 3 after ch2 grant, then ch0 and ch3
    bus.in_valid = 4'b0100;
    bus.in_data  = 16'h0900;
    tick();
    bus.in_valid = '0;
    tick();
    expect_out("wrap.ch2", 1, 9, 2);
    bus.in_valid = 4'b1001;
    bus.in_data  = 16'hC00B;
    tick();
    bus.in_valid = '0;
    tick();
`ifdef RR_MUX4_FIXED_PRIO_EN
    expect_out("wrap.a", 1, 4'hB, 0);
    tick();
    expect_out("wrap.b", 1, 4'hC, 3);
`else
    expect_out("wrap.a", 1, 4'hC, 3);
    tick();
    expect_out("wrap.b", 1, 4'hB, 0);
`endif
    tick();

    // Reset mid-operation
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = 16'hDCBA;
    tick();
    bus.in_valid = '0;
    tick();
    chk("mid.valid", 32'(bus.out_valid), 1);
    rst = 1'b1;
    tick();
    chk("mid.ready", 32'(bus.in_ready), 32'hF);
    expect_out("mid.rst", 0, 0, 0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      tick();
      expect_out("mid.stale", 0, 0, 0);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = 4'($urandom);
      bus.in_data   = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      rst           = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
